norflash_gen: RTL and testbench

NORFLASH_GEN -- requirements
Module: norflash_gen

---
 rtl/norflash_gen.sv | 249 ++++++++++++++++++++++++
 tb/tb_norflash_gen.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/norflash_gen.sv
// rtl/norflash_gen.sv - Wishbone to asynchronous NOR flash bridge (optional page mode: NORFLASH_PAGEMODE_EN)
module norflash_gen #(
    parameter int FLASH_DW    = 16,
    parameter int ADR_WIDTH   = 22,
    parameter int RD_TIMING   = 12,
    parameter int WR_TIMING   = 16,
    parameter int PAGE_TIMING = 4,
    parameter int PAGE_BITS   = 3
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    input  logic [31:0]          wb_adr_i,
    input  logic [31:0]          wb_dat_i,
    output logic [31:0]          wb_dat_o,
    input  logic [3:0]           wb_sel_i,
    input  logic                 wb_cyc_i,
    input  logic                 wb_stb_i,
    input  logic                 wb_we_i,
    output logic                 wb_ack_o,
    output logic [ADR_WIDTH-1:0] flash_adr,
    inout  wire  [FLASH_DW-1:0]  flash_d,
    output logic                 flash_oe_n,
    output logic                 flash_we_n
);

    localparam int N   = 32 / FLASH_DW;
    localparam int BPL = FLASH_DW / 8;
    localparam int BB  = $clog2(BPL);
    localparam int LB  = $clog2(N);
    localparam int LW  = (LB > 0) ? LB : 1;
    localparam logic [ADR_WIDTH-1:0] LANE_MASK = ADR_WIDTH'(N - 1);

    typedef enum logic [2:0] {IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD, ACK, DEAD} state_t;

    state_t                r_state, w_state_nxt;
    logic [7:0]            r_cnt, w_cnt_nxt;
    logic [LW-1:0]         r_lane, w_lane_nxt, w_wr_lane;
    logic [ADR_WIDTH-1:0]  r_base, r_flash_adr, w_base, w_lane_adr;
    logic [N-1:0]          r_lanes, w_lanes_in;
    logic [3:0]            r_sel;
    logic [FLASH_DW-1:0]   r_wdata, w_wr_data;
    logic [31:0]           r_rbuf, w_rbuf_nxt, r_dat_o;
    logic                  w_req, w_wr_ok, w_lane_go, w_sample, w_rd_done, w_rd_none;
    logic                  w_wr_go, w_wr_req, w_drive;
    logic [LW:0]           w_find;
    logic                  w_unused;
`ifdef NORFLASH_PAGEMODE_EN
    logic                  r_pg_valid, w_prev_ok;
    logic [ADR_WIDTH-1:0]  r_last_adr, w_prev_adr;
`else
    // Page parameters have no effect unless page mode is built in.
    if (PAGE_TIMING < 1 || PAGE_BITS < 0) begin : g_page_cfg_ignored
    end
`endif

    // Byte-select bits belonging to lane k (lane 0 holds the lowest byte addresses, sel bit 3).
    function automatic logic [3:0] lane_sel_mask(input int k);
        return 4'(((1 << BPL) - 1) << (4 - (k + 1) * BPL));
    endfunction

    // Lowest selected lane at or above 'start'; MSB of the result flags that one was found.
    function automatic logic [LW:0] find_lane(input logic [N-1:0] mask, input int start);
        logic          found;
        logic [LW-1:0] idx;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            if (!found && k >= start && mask[k]) begin
                found = 1'b1;
                idx   = LW'(k);
            end
        end
        return {found, idx};
    endfunction

    function automatic logic [ADR_WIDTH-1:0] lane_adr(input logic [ADR_WIDTH-1:0] base,
                                                      input logic [LW-1:0] lane);
        return (base & ~LANE_MASK) | (ADR_WIDTH'(lane) & LANE_MASK);
    endfunction

    function automatic logic [31:0] byte_mask(input logic [3:0] sel);
        return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
    endfunction

    assign w_req    = wb_cyc_i & wb_stb_i;
    assign w_base   = wb_adr_i[ADR_WIDTH+BB-1:BB];
    assign w_unused = ^wb_adr_i;

    // Decode which lanes the request touches and whether a write hits exactly one whole lane.
    always_comb begin
        w_lanes_in = '0;
        w_wr_ok    = 1'b0;
        w_wr_lane  = '0;
        for (int k = 0; k < N; k++) begin
            w_lanes_in[k] = |(wb_sel_i & lane_sel_mask(k));
            if (wb_sel_i == lane_sel_mask(k)) begin
                w_wr_ok   = 1'b1;
                w_wr_lane = LW'(k);
            end
        end
        w_wr_data = FLASH_DW'(wb_dat_i >> ((N - 1 - int'(w_wr_lane)) * FLASH_DW));
    end

    // Merge the flash word being sampled into its slot of the read buffer.
    always_comb begin
        w_rbuf_nxt = r_rbuf;
        w_rbuf_nxt[31 - int'(r_lane) * FLASH_DW -: FLASH_DW] = flash_d;
    end

    // Next-state, lane sequencing and access-counter reload.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_lane_nxt  = r_lane;
        w_lane_go   = 1'b0;
        w_sample    = 1'b0;
        w_rd_done   = 1'b0;
        w_rd_none   = 1'b0;
        w_wr_go     = 1'b0;
        w_wr_req    = 1'b0;
        w_find      = '0;
        w_lane_adr  = '0;
        case (r_state)
            IDLE: begin
                if (w_req) begin
                    if (wb_we_i) begin
                        w_wr_req = 1'b1;
                        if (w_wr_ok) begin
                            w_state_nxt = WR_SETUP;
                            w_wr_go     = 1'b1;
                        end else begin
                            w_state_nxt = ACK;
                        end
                    end else begin
                        w_find = find_lane(w_lanes_in, 0);
                        if (w_find[LW]) begin
                            w_state_nxt = RD;
                            w_lane_go   = 1'b1;
                            w_lane_nxt  = w_find[LW-1:0];
                        end else begin
                            w_state_nxt = ACK;
                            w_rd_none   = 1'b1;
                        end
                    end
                end
            end
            RD: begin
                if (r_cnt == 8'd0) begin
                    w_sample = 1'b1;
                    w_find   = find_lane(r_lanes, int'(r_lane) + 1);
                    if (w_find[LW]) begin
                        w_lane_go  = 1'b1;
                        w_lane_nxt = w_find[LW-1:0];
                    end else begin
                        w_state_nxt = ACK;
                        w_rd_done   = 1'b1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - 8'd1;
                end
            end
            WR_SETUP: begin
                w_state_nxt = WR_PULSE;
                w_cnt_nxt   = 8'(WR_TIMING - 1);
            end
            WR_PULSE: begin
                if (r_cnt == 8'd0) w_state_nxt = WR_HOLD;
                else               w_cnt_nxt   = r_cnt - 8'd1;
            end
            WR_HOLD:  w_state_nxt = ACK;
            ACK:      w_state_nxt = DEAD;
            // Wait out the strobe of the finished cycle so it cannot start another.
            DEAD:     if (!w_req) w_state_nxt = IDLE;
            default:  w_state_nxt = IDLE;
        endcase

        w_lane_adr = lane_adr((r_state == IDLE) ? w_base : r_base, w_lane_nxt);
`ifdef NORFLASH_PAGEMODE_EN
        // While chaining lanes the previous read address is the one on the bus right now.
        w_prev_adr = (r_state == RD) ? r_flash_adr : r_last_adr;
        w_prev_ok  = (r_state == RD) || r_pg_valid;
        if (w_lane_go)
            w_cnt_nxt = (w_prev_ok && ((w_lane_adr >> PAGE_BITS) == (w_prev_adr >> PAGE_BITS)))
                        ? 8'(PAGE_TIMING - 1) : 8'(RD_TIMING - 1);
`else
        if (w_lane_go)
            w_cnt_nxt = 8'(RD_TIMING - 1);
`endif
    end

    // State register and access counter.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_lane  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_lane  <= w_lane_nxt;
        end
    end

    // Request capture, flash address/data, read assembly and page tracking.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_base      <= '0;
            r_lanes     <= '0;
            r_sel       <= '0;
            r_flash_adr <= '0;
            r_wdata     <= '0;
            r_rbuf      <= '0;
            r_dat_o     <= '0;
`ifdef NORFLASH_PAGEMODE_EN
            r_pg_valid  <= 1'b0;
            r_last_adr  <= '0;
`endif
        end else begin
            if (r_state == IDLE && w_req) begin
                r_base  <= w_base;
                r_lanes <= w_lanes_in;
                r_sel   <= wb_sel_i;
            end
            if (w_lane_go)    r_flash_adr <= w_lane_adr;
            else if (w_wr_go) r_flash_adr <= lane_adr(w_base, w_wr_lane);
            if (w_wr_go)   r_wdata <= w_wr_data;
            if (w_sample)  r_rbuf  <= w_rbuf_nxt;
            if (w_rd_done)      r_dat_o <= w_rbuf_nxt & byte_mask(r_sel);
            else if (w_rd_none) r_dat_o <= '0;
`ifdef NORFLASH_PAGEMODE_EN
            if (w_sample) begin
                r_pg_valid <= 1'b1;
                r_last_adr <= r_flash_adr;
            end else if (w_wr_req) begin
                r_pg_valid <= 1'b0;
            end
`endif
        end
    end

    assign w_drive    = (r_state == WR_SETUP) || (r_state == WR_PULSE) || (r_state == WR_HOLD);
    assign flash_d    = w_drive ? r_wdata : {FLASH_DW{1'bz}};
    assign flash_oe_n = (r_state != RD);
    assign flash_we_n = (r_state != WR_PULSE);
    assign flash_adr  = r_flash_adr;
    assign wb_ack_o   = (r_state == ACK);
    assign wb_dat_o   = r_dat_o;

endmodule

// File: tb/tb_norflash_gen.sv
// tb/tb_norflash_gen.sv - directed self-checking bench for norflash_gen
module tb_norflash_gen;

`ifdef NORFLASH_PAGEMODE_EN
    localparam bit PM = 1'b1;
`else
    localparam bit PM = 1'b0;
`endif

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic [31:0] wb_adr_i = '0;
    logic [31:0] wb_dat_i = '0;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_i = '0;
    logic        wb_cyc_i = 1'b0;
    logic        wb_stb_i = 1'b0;
    logic        wb_we_i = 1'b0;
    logic        wb_ack_o;
    logic [21:0] flash_adr;
    wire  [15:0] flash_d;
    logic        flash_oe_n;
    logic        flash_we_n;

    int checks = 0;
    int errors = 0;

    always #5 sys_clk = ~sys_clk;

    norflash_gen dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .wb_adr_i   (wb_adr_i),
        .wb_dat_i   (wb_dat_i),
        .wb_dat_o   (wb_dat_o),
        .wb_sel_i   (wb_sel_i),
        .wb_cyc_i   (wb_cyc_i),
        .wb_stb_i   (wb_stb_i),
        .wb_we_i    (wb_we_i),
        .wb_ack_o   (wb_ack_o),
        .flash_adr  (flash_adr),
        .flash_d    (flash_d),
        .flash_oe_n (flash_oe_n),
        .flash_we_n (flash_we_n)
    );

    // Flash model: returns its word address plus one while output-enabled.
    assign flash_d = flash_oe_n ? 16'hzzzz : (flash_adr[15:0] + 16'd1);
    for (genvar gi = 0; gi < 16; gi++) begin : g_pu
        pullup (flash_d[gi]);
    end

    // Bus monitor sampled on the falling edge.
    int          acc_cnt = 0;
    int          we_cnt = 0;
    int          ack_cnt = 0;
    logic        prev_oe_n = 1'b1;
    logic [21:0] prev_adr = '0;
    logic [21:0] acc_adr0 = '0;
    logic [21:0] acc_adr1 = '0;
    logic [21:0] wr_adr = '0;
    logic [15:0] wr_seen = '0;

    always @(negedge sys_clk) begin
        if (!flash_oe_n && (prev_oe_n || flash_adr != prev_adr)) begin
            acc_cnt  <= acc_cnt + 1;
            acc_adr0 <= acc_adr1;
            acc_adr1 <= flash_adr;
        end
        if (!flash_we_n) begin
            we_cnt  <= we_cnt + 1;
            wr_seen <= flash_d;
            wr_adr  <= flash_adr;
        end
        if (wb_ack_o) ack_cnt <= ack_cnt + 1;
        prev_oe_n <= flash_oe_n;
        prev_adr  <= flash_adr;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One Wishbone cycle; lat is the number of clocks until ack is first seen (-1 on timeout).
    task automatic wb_cycle(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                            input logic [31:0] dat, input int hold, output int lat);
        @(negedge sys_clk);
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        wb_we_i  = we;
        wb_adr_i = adr;
        wb_sel_i = sel;
        wb_dat_i = dat;
        lat = -1;
        for (int n = 1; n <= 400; n++) begin
            @(negedge sys_clk);
            if (wb_ack_o) begin
                lat = n;
                break;
            end
        end
        repeat (hold) @(negedge sys_clk);
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        wb_we_i  = 1'b0;
        repeat (3) @(negedge sys_clk);
    endtask

    int lat, a0, w0, k0;

    initial begin
        repeat (3) @(negedge sys_clk);
        check("rst_ack", 32'(wb_ack_o), 32'd0);
        check("rst_dat", wb_dat_o, 32'h0);
        check("rst_oe_n", 32'(flash_oe_n), 32'd1);
        check("rst_we_n", 32'(flash_we_n), 32'd1);
        check("rst_adr", 32'(flash_adr), 32'h0);
        check("rst_flash_d_released", 32'(flash_d), 32'h0000ffff);
        sys_rst_n = 1'b1;
        repeat (2) @(negedge sys_clk);

        a0 = acc_cnt;
        wb_cycle(1'b0, 32'h0000fff0, 4'b1111, 32'h0, 0, lat);
        check("rd2_lat", 32'(lat), PM ? 32'd17 : 32'd25);
        check("rd2_dat", wb_dat_o, 32'h7ff97ffa);
        check("rd2_nacc", 32'(acc_cnt - a0), 32'd2);
        check("rd2_adr0", 32'(acc_adr0), 32'h7ff8);
        check("rd2_adr1", 32'(acc_adr1), 32'h7ff9);

        a0 = acc_cnt;
        wb_cycle(1'b0, 32'h0000fff0, 4'b0011, 32'h0, 0, lat);
        check("rd_lane1_lat", 32'(lat), PM ? 32'd5 : 32'd13);
        check("rd_lane1_dat", wb_dat_o, 32'h00007ffa);
        check("rd_lane1_nacc", 32'(acc_cnt - a0), 32'd1);
        check("rd_lane1_adr", 32'(acc_adr1), 32'h7ff9);

        a0 = acc_cnt;
        k0 = ack_cnt;
        wb_cycle(1'b0, 32'h0000fff0, 4'b1000, 32'h0, 3, lat);
        check("rd_byte_lat", 32'(lat), PM ? 32'd5 : 32'd13);
        check("rd_byte_dat", wb_dat_o, 32'h7f000000);
        check("stb_hold_nacc", 32'(acc_cnt - a0), 32'd1);
        check("stb_hold_nack", 32'(ack_cnt - k0), 32'd1);

        w0 = we_cnt;
        wb_cycle(1'b1, 32'h00000010, 4'b1100, 32'h00AA0000, 0, lat);
        check("wr_lat", 32'(lat), 32'd19);
        check("wr_pulse_len", 32'(we_cnt - w0), 32'd16);
        check("wr_data", 32'(wr_seen), 32'h00aa);
        check("wr_adr", 32'(wr_adr), 32'h8);
        check("dat_hold_after_wr", wb_dat_o, 32'h7f000000);

        w0 = we_cnt;
        wb_cycle(1'b1, 32'h00000010, 4'b1110, 32'h12345678, 0, lat);
        check("wr_bad_sel_lat", 32'(lat), 32'd1);
        check("wr_bad_sel_nwe", 32'(we_cnt - w0), 32'd0);

        wb_cycle(1'b0, 32'h00000010, 4'b1111, 32'h0, 0, lat);
        check("rd10_lat", 32'(lat), PM ? 32'd17 : 32'd25);
        check("rd10_dat", wb_dat_o, 32'h0009000a);
        wb_cycle(1'b0, 32'h00000014, 4'b1111, 32'h0, 0, lat);
        check("rd14_lat", 32'(lat), PM ? 32'd9 : 32'd25);
        check("rd14_dat", wb_dat_o, 32'h000b000c);

        a0 = acc_cnt;
        wb_cycle(1'b0, 32'h00000020, 4'b0000, 32'h0, 0, lat);
        check("rd_nosel_lat", 32'(lat), 32'd1);
        check("rd_nosel_nacc", 32'(acc_cnt - a0), 32'd0);

        // Reset in the middle of the write pulse.
        @(negedge sys_clk);
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        wb_we_i  = 1'b1;
        wb_adr_i = 32'h00000010;
        wb_sel_i = 4'b0011;
        wb_dat_i = 32'h00001234;
        repeat (6) @(negedge sys_clk);
        check("mid_wr_we_low", 32'(flash_we_n), 32'd0);
        check("mid_wr_flash_d", 32'(flash_d), 32'h1234);
        sys_rst_n = 1'b0;
        wb_cyc_i  = 1'b0;
        wb_stb_i  = 1'b0;
        wb_we_i   = 1'b0;
        #1;
        check("rst_wr_we_n", 32'(flash_we_n), 32'd1);
        check("rst_wr_flash_d", 32'(flash_d), 32'h0000ffff);
        check("rst_wr_adr", 32'(flash_adr), 32'h0);
        repeat (2) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        @(negedge sys_clk);
        a0 = acc_cnt;
        w0 = we_cnt;
        repeat (10) @(negedge sys_clk);
        check("post_rst_nwe", 32'(we_cnt - w0), 32'd0);
        check("post_rst_nacc", 32'(acc_cnt - a0), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
